// File: rtl/unit_acc_pkg.sv
// Shared FSM state encoding and counter sizing for depth_accumulator.
// Counter widths come from clog2, with a floor of one bit for degenerate sizes.
package unit_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LAST  = 2'd2,
    FLUSH = 2'd3
  } acc_state_e;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/acc_buffer.sv
// Per-pixel partial-sum store: register array, combinational read, synchronous write.
// Not reset; the first channel of every map overwrites each entry before it is read.
module acc_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 81,
  parameter int ADDR_W     = 7
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/depth_accumulator.sv
// Sums IFM_DEPTH raster-order maps pixelwise; last-channel pixels leave via a 1-deep output reg (1-cycle latency).
// out_ready backpressures the input only in LAST; `ifdef ACC_RELU_EN clamps negative final sums to 0.
module depth_accumulator
  import unit_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFM_SIZE   = 9,
  parameter int IFM_DEPTH  = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int NPIX  = OFM_SIZE * OFM_SIZE;
  localparam int PIX_W = cnt_width(NPIX);
  localparam int CH_W  = cnt_width(IFM_DEPTH);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(IFM_DEPTH - 1);
  localparam acc_state_e START_STATE = (IFM_DEPTH == 1) ? LAST : ACCUM;

  acc_state_e            state_q, state_d;
  logic [PIX_W-1:0]      pix_q, pix_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [CH_W-1:0]       ch_inc;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  done_q, done_d;

  logic                  in_ready_w;
  logic                  xfer;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] result;

  acc_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (NPIX),
    .ADDR_W    (PIX_W)
  ) u_buf (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(pix_q),
    .wr_data(wr_data),
    .rd_addr(pix_q),
    .rd_data(rd_data)
  );

  always_comb begin
    in_ready_w = 1'b0;
    unique case (state_q)
      ACCUM:   in_ready_w = 1'b1;
      LAST:    in_ready_w = !out_valid_q || out_ready;
      default: in_ready_w = 1'b0;
    endcase
  end

  assign xfer    = in_valid && in_ready_w;
  assign wr_en   = xfer && (state_q == ACCUM);
  assign wr_data = (ch_q == '0) ? in_data : (rd_data + in_data);
  assign ch_inc  = ch_q + 1'b1;

  // A single-channel map never touches the buffer, so the input passes straight through.
  if (IFM_DEPTH == 1) begin : g_pass
    assign sum = in_data;
  end else begin : g_add
    assign sum = rd_data + in_data;
  end

`ifdef ACC_RELU_EN
  assign result = sum[DATA_WIDTH-1] ? '0 : sum;
`else
  assign result = sum;
`endif

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    ch_d        = ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START_STATE;
          pix_d   = '0;
          ch_d    = '0;
        end
      end
      ACCUM: begin
        if (xfer) begin
          if (pix_q == PIX_LAST) begin
            pix_d = '0;
            ch_d  = ch_inc;
            if (ch_inc == CH_LAST) begin
              state_d = LAST;
            end
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      LAST: begin
        // A new transfer overrides the drop above: the register reloads in the same cycle.
        if (xfer) begin
          out_valid_d = 1'b1;
          out_data_d  = result;
          if (pix_q == PIX_LAST) begin
            pix_d   = '0;
            state_d = FLUSH;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (out_valid_q && out_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
          pix_d   = '0;
          ch_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      ch_q        <= ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_w;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  out_hold_a: assert property (@(posedge clk) disable iff (reset)
    out_valid_q && !out_ready |=> out_valid_q && $stable(out_data_q));

endmodule

// File: tb/tb_depth_accumulator.sv
// Bench for depth_accumulator: 2x2 map over 3 channels plus a single-channel instance.
// Expected pixels come from a vector table; a queue scoreboard checks them as they leave.
module tb_depth_accumulator;

  localparam int DW = 32;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, busy, done;
  logic [DW-1:0] out_data;

  logic          start1, in_valid1, out_ready1;
  logic [DW-1:0] in_data1;
  logic          in_ready1, out_valid1, busy1, done1;
  logic [DW-1:0] out_data1;

  depth_accumulator #(.DATA_WIDTH(DW), .OFM_SIZE(2), .IFM_DEPTH(3)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  depth_accumulator #(.DATA_WIDTH(DW), .OFM_SIZE(2), .IFM_DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .busy(busy1), .done(done1)
  );

  typedef struct {
    logic [DW-1:0] c0, c1, c2;
    logic [DW-1:0] exp_raw, exp_relu;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } sb_t;

  vec_t tab[12];
  sb_t  sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   last_acc_cyc = 0;
  logic prev_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Output monitor: latency on first appearance, value on acceptance.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (!prev_hold) begin
        if (sbq.size() == 0) flag("unexpected_output");
        else check("latency", cyc, sbq[0].cyc);
      end
      if (out_ready) begin
        if (sbq.size() > 0) begin
          check("out_data", out_data, sbq[0].data);
          void'(sbq.pop_front());
        end
        acc_cnt++;
        last_acc_cyc = cyc;
      end
    end
    prev_hold = !reset && out_valid && !out_ready;
  end

  function automatic logic [DW-1:0] pick_exp(input vec_t v);
`ifdef ACC_RELU_EN
    return v.exp_relu;
`else
    return v.exp_raw;
`endif
  endfunction

  task automatic send(input logic [DW-1:0] d, input bit push, input logic [DW-1:0] e);
    int g = 0;
    sb_t s;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) flag("send_timeout");
    else if (push) begin
      s.data = e;
      s.cyc  = cyc + 1;
      sbq.push_back(s);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_map(input int base, input bit glitch);
    vec_t          v;
    logic [DW-1:0] d;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      for (int p = 0; p < 4; p++) begin
        v = tab[base + p];
        d = (ch == 0) ? v.c0 : (ch == 1) ? v.c1 : v.c2;
        if (glitch && ch == 1 && p == 1) start = 1'b1;
        send(d, ch == 2, pick_exp(v));
        start = 1'b0;
        if (glitch && ch == 1 && p == 1) check("busy_on_restart", busy, 1'b1);
      end
    end
  endtask

  task automatic wait_done();
    int g = 0;
    @(negedge clk);
    while (!done && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("done_seen", done, 1'b1);
    check("done_timing", cyc, last_acc_cyc + 1);
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    check("idle_busy", busy, 1'b0);
  endtask

  task automatic stall_ctl();
    int g = 0;
    while (!(out_valid && acc_cnt == 1) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) flag("stall_trigger");
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, 32'd222);
      check("stall_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  initial begin
    tab[0]  = '{32'd1, 32'd10, 32'd100, 32'd111, 32'd111};
    tab[1]  = '{32'd2, 32'd20, 32'd200, 32'd222, 32'd222};
    tab[2]  = '{32'd3, 32'd30, 32'd300, 32'd333, 32'd333};
    tab[3]  = '{32'd4, 32'd40, 32'd400, 32'd444, 32'd444};
    tab[4]  = '{32'h7FFFFFFF, 32'd1, 32'd0, 32'h80000000, 32'd0};
    tab[5]  = '{32'hFFFFFFFB, 32'd2, 32'd1, 32'hFFFFFFFE, 32'd0};
    tab[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0};
    tab[7]  = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd1};
    for (int i = 8; i < 12; i++) tab[i] = '{32'd1, 32'd1, 32'd1, 32'd3, 32'd3};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    start1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_done", done, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // in_valid while idle must be ignored
    in_valid = 1'b1;
    in_data  = 32'd77;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", in_ready, 1'b0);
      check("idle_busy_hold", busy, 1'b0);
      check("idle_out_valid", out_valid, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    run_map(0, 1'b0);
    wait_done();

    acc_cnt = 0;
    fork
      run_map(0, 1'b0);
      stall_ctl();
    join
    wait_done();

    run_map(4, 1'b0);
    wait_done();

    run_map(0, 1'b1);
    wait_done();

    // abandon a map after five ACCUM transfers
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) send(32'd999, 1'b0, '0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", busy, 1'b0);
    check("midreset_in_ready", in_ready, 1'b0);
    run_map(8, 1'b0);
    wait_done();

    // single-channel pass-through
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int g = 0;
      in_valid1 = 1'b1;
      in_data1  = 32'd5 + i;
      @(negedge clk);
      while (!in_ready1 && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (!in_ready1) flag("d1_send_timeout");
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      @(negedge clk);
      check("d1_valid", out_valid1, 1'b1);
      check("d1_data", out_data1, 32'd5 + i);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("d1_done", done1, 1'b1);
    @(negedge clk);
    check("d1_done_pulse", done1, 1'b0);
    check("d1_busy", busy1, 1'b0);

    check("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/depth_accumulator.md
DEPTH_ACCUMULATOR -- requirements
Module: depth_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the two's-complement integer datapath.
REQ-002 SHALL have parameter OFM_SIZE, default 9: output map side (IFM_SIZE-KERNAL_SIZE+1).
REQ-003 SHALL have parameter IFM_DEPTH, default 18: number of input channels summed per output map.
REQ-004 SHALL have port clk  input  1: single clock, all logic on the rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port start  input  1: one-cycle pulse that begins one output map.
REQ-007 SHALL have port in_valid  input  1: in_data valid (driven from the convolution unit's output).
REQ-008 SHALL have port in_ready  output  1: block accepts in_data this cycle.
REQ-009 SHALL have port in_data  input  DATA_WIDTH: one partial sum in raster order per channel.
REQ-010 SHALL have port out_valid  output  1: out_data holds a final pixel.
REQ-011 SHALL have port out_ready  input  1: downstream accepts out_data.
REQ-012 SHALL have port out_data  output  DATA_WIDTH: channel-summed pixel.
REQ-013 SHALL have port busy  output  1: high outside IDLE.
REQ-014 SHALL have port done  output  1: one-cycle pulse after the last pixel is accepted downstream.

Function
REQ-015 SHALL have states IDLE, ACCUM, LAST, FLUSH.
- IDLE->ACCUM on start (IDLE->LAST if IFM_DEPTH==1).
- start is ignored outside IDLE.
REQ-016 SHALL hold an OFM_SIZE*OFM_SIZE x DATA_WIDTH buffer, a pixel counter pix (0..OFM_SIZE^2-1) and a channel counter ch (0..IFM_DEPTH-1).
- A transfer is in_valid && in_ready.
REQ-017 In ACCUM, in_ready SHALL be 1.
- On a transfer with ch==0: buf[pix] <= in_data.
- On a transfer with ch>0: buf[pix] <= buf[pix]+in_data.
- pix increments; at OFM_SIZE^2-1 it wraps to 0 and ch increments.
- When ch reaches IFM_DEPTH-1, the state goes to LAST.
REQ-018 In LAST, in_ready SHALL equal !out_valid || out_ready (one-deep output register).
- A transfer loads out_data <= buf[pix]+in_data (in_data alone if IFM_DEPTH==1) and sets out_valid the next cycle: one-cycle latency.
- The buffer is not written.
REQ-019 On the LAST transfer with pix==OFM_SIZE^2-1, the state SHALL go to FLUSH.
REQ-020 In FLUSH, in_ready SHALL be 0.
- When out_valid && out_ready: done=1 for one cycle, then IDLE with counters cleared.
REQ-021 out_valid SHALL stay high with out_data stable until out_ready; it drops when out_ready is high and no new transfer occurs in the same cycle.
REQ-022 Addition SHALL be modulo 2^DATA_WIDTH: wraps, no saturation, no overflow flag.
REQ-023 in_valid in IDLE SHALL be ignored (in_ready=0 in IDLE).

Reset
REQ-024 On reset SHALL set: state=IDLE, pix=0, ch=0, out_valid=0, out_data=0, done=0, in_ready=0, busy=0.
- Buffer contents are not reset.
REQ-025 Reset mid-map SHALL abandon the map; the next start begins cleanly because ch==0 overwrites the buffer.

Configuration
REQ-026 Macro ACC_RELU_EN:
- If defined, out_data SHALL be 0 when the sum is negative (MSB set), else the sum.
- If undefined, out_data SHALL be the raw wrapped sum.
- The ACCUM path is unaffected either way.

Structure
REQ-027 Package unit_acc_pkg SHALL hold the state enum and a counter-width constant function (clog2-based) for pix and ch.
REQ-028 The buffer SHALL be a sub-module acc_buffer: register array, combinational read, synchronous write.

Verification (OFM_SIZE=2, IFM_DEPTH=3, DATA_WIDTH=32 unless noted)
REQ-029 start; channels {1,2,3,4},{10,20,30,40},{100,200,300,400}; out_ready=1 -> out_data 111,222,333,444, each 1 cycle after its transfer; done 1 cycle after 444 is accepted.
REQ-030 Same stimulus, out_ready low for 3 cycles at the 2nd output -> out_valid held, out_data 222 stable, in_ready=0 until accepted, no loss.
REQ-031 Inputs 0x7FFFFFFF,1,0 at pix0 -> 0x80000000; with ACC_RELU_EN defined -> 0.
REQ-032 Reset asserted after 5 ACCUM transfers, then start with all-ones channels -> outputs 3,3,3,3; stale data has no effect.
REQ-033 start while busy, and in_valid in IDLE -> no effect on state, counters or outputs.
REQ-034 IFM_DEPTH=1, inputs {5,6,7,8} -> outputs 5,6,7,8 passed through from LAST directly.
